// File: rtl/mtm_alu_serializer_if.sv
// mtm_alu_serializer_if: response-word strobe in, serial line and status out
interface mtm_alu_serializer_if;
  logic [54:0] data_in;
  logic data_ready;
  logic sout;
  logic busy;
  logic overrun;
  modport master(output data_in, data_ready, input sout, busy, overrun);
  modport slave(input data_in, data_ready, output sout, busy, overrun);
endinterface

// File: rtl/mtm_alu_serializer.sv
// mtm_alu_serializer: shifts the ALU response word out MSB-first on an idle-high serial line
module mtm_alu_serializer #(
  parameter int CLKS_PER_BIT = 1
) (
  input logic clk,
  input logic rst,
  mtm_alu_serializer_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [54:0] sh, sh_n, word;
  logic [5:0] bc, bc_n, len;
  logic [CW-1:0] cc, cc_n;
  logic sout_q, busy_q, ovr_q, ovr_n;
  logic bit_end, last, load;
  assign word = bus.data_in[8] ? {bus.data_in[10:0], 44'd0} : bus.data_in;
  assign len = bus.data_in[8] ? 6'd11 : 6'd55;
  always_comb begin
    bit_end = (state == SHIFT) && (cc == C_LAST);
    last = bit_end && (bc == 6'd1);
    load = bus.data_ready && ((state == IDLE) || last);
    state_n = load ? SHIFT : last ? IDLE : state;
    sh_n = load ? word : bit_end ? sh << 1 : sh;
    bc_n = load ? len : bit_end ? bc - 6'd1 : bc;
    cc_n = (load || bit_end || state == IDLE) ? '0 : cc + 1'b1;
    ovr_n = bus.data_ready && (state == SHIFT) && !last;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh <= '0;
      bc <= '0;
      cc <= '0;
      sout_q <= 1'b1;
      busy_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      bc <= bc_n;
      cc <= cc_n;
      sout_q <= (state_n == SHIFT) ? sh_n[54] : 1'b1;
      busy_q <= state_n == SHIFT;
      ovr_q <= ovr_n;
    end
  end
  assign bus.sout = sout_q;
  assign bus.busy = busy_q;
  assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_mtm_alu_serializer.sv
// tb_mtm_alu_serializer: directed and random checks of the serializer at 1 and 4 clocks per bit
module tb_mtm_alu_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  bit exp_q[$];
  mtm_alu_serializer_if i1();
  mtm_alu_serializer_if i4();
  mtm_alu_serializer #(.CLKS_PER_BIT(1)) d1(.clk(clk), .rst(rst), .bus(i1.slave));
  mtm_alu_serializer #(.CLKS_PER_BIT(4)) d4(.clk(clk), .rst(rst), .bus(i4.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [54:0] mk(input logic [31:0] c, input logic [7:0] ctl);
    return {2'b00, c[31:24], 1'b1, 2'b00, c[23:16], 1'b1, 2'b00, c[15:8], 1'b1,
            2'b00, c[7:0], 1'b1, 2'b01, ctl, 1'b1};
  endfunction
  function automatic logic [54:0] rnd();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[54:0];
  endfunction
  task automatic frame(input bit t, input logic [7:0] d);
    exp_q.push_back(1'b0);
    exp_q.push_back(t);
    for (int k = 7; k >= 0; k--) exp_q.push_back(d[k]);
    exp_q.push_back(1'b1);
  endtask
  task automatic model(input logic [31:0] c, input logic [7:0] ctl);
    exp_q.delete();
    if (!ctl[7]) for (int k = 3; k >= 0; k--) frame(1'b0, c[8*k +: 8]);
    frame(1'b1, ctl);
  endtask
  task automatic drive(input int w, input logic dr, input logic [54:0] d);
    if (w == 4) begin
      i4.data_ready = dr;
      i4.data_in = d;
    end else begin
      i1.data_ready = dr;
      i1.data_in = d;
    end
  endtask
  task automatic obs(input int w, output logic s, output logic b, output logic o);
    s = (w == 4) ? i4.sout : i1.sout;
    b = (w == 4) ? i4.busy : i1.busy;
    o = (w == 4) ? i4.overrun : i1.overrun;
  endtask
  task automatic chk_idle(input int w, input string tag);
    logic s, b, o;
    obs(w, s, b, o);
    chk({tag, " idle sout"}, s, 1);
    chk({tag, " idle busy"}, b, 0);
    chk({tag, " idle overrun"}, o, 0);
  endtask
  task automatic start(input int w, input logic [31:0] c, input logic [7:0] ctl);
    drive(w, 1'b1, mk(c, ctl));
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(input int w, input logic [31:0] c, input logic [7:0] ctl, input int strobe_at,
                      input logic [31:0] nc, input logic [7:0] nctl, input string tag);
    int total;
    logic s, b, o;
    model(c, ctl);
    total = exp_q.size() * w;
    for (int i = 0; i < total; i++) begin
      drive(w, 1'b0, rnd());
      obs(w, s, b, o);
      chk($sformatf("%s sout[%0d]", tag, i), s, exp_q[i / w]);
      chk($sformatf("%s busy[%0d]", tag, i), b, 1);
      chk($sformatf("%s overrun[%0d]", tag, i), o, (strobe_at >= 0 && i == strobe_at + 1) ? 1 : 0);
      if (i == strobe_at) drive(w, 1'b1, mk(nc, nctl));
      @(posedge clk);
      #1;
    end
    if (strobe_at != total - 1) begin
      drive(w, 1'b0, rnd());
      chk_idle(w, tag);
    end
  endtask
  initial begin
    logic s, b, o;
    logic [31:0] c, nc;
    logic [7:0] ctl, nctl;
    int w, total, mode, at;
    drive(1, 1'b0, '0);
    drive(4, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk_idle(1, "reset1");
    chk_idle(4, "reset4");
    rst = 1'b0;
    start(1, 32'h12345678, 8'h05);
    xfer(1, 32'h12345678, 8'h05, -1, 0, 0, "normal");
    start(1, 32'h0, 8'hC9);
    xfer(1, 32'h0, 8'hC9, -1, 0, 0, "error");
    start(4, 32'h12345678, 8'h05);
    xfer(4, 32'h12345678, 8'h05, -1, 0, 0, "pace");
    start(1, 32'h12345678, 8'h05);
    xfer(1, 32'h12345678, 8'h05, 20, $urandom, 8'($urandom), "overrun");
    start(1, 32'h12345678, 8'h05);
    xfer(1, 32'h12345678, 8'h05, 54, 32'hFFFFFFFF, 8'h05, "b2b_a");
    xfer(1, 32'hFFFFFFFF, 8'h05, -1, 0, 0, "b2b_b");
    c = $urandom;
    ctl = 8'($urandom) & 8'h7F;
    model(c, ctl);
    start(1, c, ctl);
    for (int i = 0; i < 30; i++) begin
      drive(1, 1'b0, rnd());
      obs(1, s, b, o);
      chk($sformatf("pre_rst sout[%0d]", i), s, exp_q[i]);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    drive(1, 1'b1, rnd());
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 1'b0, rnd());
    chk_idle(1, "mid_rst");
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_idle(1, "post_rst");
    end
    start(1, 32'h12345678, 8'h05);
    xfer(1, 32'h12345678, 8'h05, -1, 0, 0, "after_rst");
    for (int n = 0; n < 8; n++) begin
      w = ($urandom_range(0, 1) == 1) ? 4 : 1;
      c = $urandom;
      ctl = 8'($urandom);
      nc = $urandom;
      nctl = 8'($urandom);
      total = (ctl[7] ? 11 : 55) * w;
      mode = $urandom_range(0, 2);
      at = (mode == 0) ? -1 : (mode == 1) ? $urandom_range(0, total - 2) : total - 1;
      start(w, c, ctl);
      xfer(w, c, ctl, at, nc, nctl, $sformatf("rand%0d", n));
      if (mode == 2) xfer(w, nc, nctl, -1, 0, 0, $sformatf("rand%0d_b2b", n));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
